channel_ctrl: RTL
=================

Name: channel_ctrl

Overview:
- Digital per-channel sequencer directly downstream of the LArPix-v2 analog channel.
- Watches the discriminator hit, freezes the CSA output, strobes the SAR ADC and captures the conversion result with a timestamp.
- Pushes each event into a small local FIFO, then resets the CSA and re-arms.
- The chip-level event router drains the FIFO through a valid/ready interface.

Parameters:
- ADCBITS, 10, ADC word width (matches analog channel)
- TS_BITS, 24, timestamp width
- HOLD_CYCLES, 2, clocks from registered hit to sample release (CSA settling)
- RESET_CYCLES, 4, clocks csa_reset is held high after a conversion
- TIMEOUT_CYCLES, 64, maximum clocks waiting for done before abort
- FIFO_DEPTH, 4, event FIFO entries (power of 2)

Ports:
- clk  in  1  primary clock
- reset_n  in  1  synchronous active-low reset
- enable  in  1  channel enable; 0 parks FSM in READY and masks hit
- hit  in  1  discriminator output (asynchronous; 2-flop synchronized internally)
- done  in  1  ADC conversion finished (asynchronous; 2-flop synchronized internally)
- dout  in  ADCBITS  ADC result, stable while done is high
- timestamp  in  TS_BITS  free-running chip timestamp
- sample  out  1  1 = ADC tracks CSA, 0 = hold
- strobe  out  1  one-cycle ADC start pulse
- csa_reset  out  1  high resets CSA
- ev_valid  out  1  FIFO non-empty
- ev_data  out  TS_BITS+ADCBITS+1  {timeout_flag, timestamp, adc_word}
- ev_ready  in  1  consumer accepts the head entry when ev_valid && ev_ready
- overflow  out  1  sticky; event lost because the FIFO was full
- busy  out  1  FSM not in READY

Behaviour:
- Reset (reset_n=0 at a clk edge): FSM=READY, sample=1, strobe=0, csa_reset=1, FIFO empty, ev_valid=0, ev_data=0, overflow=0, busy=0, counters=0.
  - csa_reset is deasserted on the first clock after reset_n rises.
- Synchronized hit_s and done_s add 2 cycles of latency.
- A rising edge of hit_s triggers; a hit held high does not retrigger.
- States:
  - READY: sample=1. On hit_s rise && enable, latch timestamp, go to HOLD.
  - HOLD: count HOLD_CYCLES, then sample=0 and go to CONVERT.
  - CONVERT: strobe=1 for exactly 1 cycle, go to WAIT_DONE.
  - WAIT_DONE: on done_s=1, latch dout and go to STORE. If TIMEOUT_CYCLES elapse without done_s, adc_word=0, timeout_flag=1, go to STORE.
  - STORE: one cycle. Write {timeout_flag, ts_latched, adc_word} if the FIFO is not full; otherwise drop it and set overflow. Go to RESET.
  - RESET: csa_reset=1, sample=1, hold for RESET_CYCLES, go to READY.
- sample returns to 1 on entry to RESET.
- Minimum dead time from hit edge to re-armed: 2 + HOLD_CYCLES + 1 + conversion + 1 + RESET_CYCLES cycles.
- Hits arriving while busy are ignored and not counted.
- enable=0 mid-event: the current event completes normally; no new trigger is taken in READY.
- FIFO:
  - First-word fall-through: ev_data reflects the head whenever ev_valid=1.
  - Simultaneous write and read when full: the read frees a slot, so the write succeeds with no overflow.
  - Simultaneous write and read when empty: the write lands and ev_valid rises the next cycle.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2·DEPTH; full = MSBs differ and LSBs equal.
- overflow clears only on reset.
- Reset mid-event: immediate return to READY with reset values; any partial event is discarded.

Decomposition:
- Package channel_ctrl_pkg:
  - state enum {READY, HOLD, CONVERT, WAIT_DONE, STORE, RESET}
  - event struct typedef {timeout_flag, ts, adc}
  - EV_WIDTH localparam function of the parameters
- Sub-module event_fifo:
  - Parameterized width and depth.
  - Synchronous active-low reset.
  - Interfaces: wr_en/full, rd_en/empty, first-word fall-through.

Test Plan:
- Basic event: timestamp=0x000100, hit pulse, ADC model returns dout=0x2A5 after 12 cycles.
  - Exactly one strobe.
  - Event {0, 0x000100, 0x2A5} appears with ev_valid.
  - csa_reset high for 4 cycles, then busy=0.
- Timeout: hit but done never asserts.
  - After 64 cycles in WAIT_DONE, event {1, ts, 0x000} is stored and the channel re-arms.
- Overflow: ev_ready=0, 5 hits spaced past dead time.
  - 4 events stored, overflow=1 after the 5th.
  - Then raise ev_ready and read 4 entries in order; overflow stays 1.
- Busy masking: second hit 3 cycles after the first → single event; held-high hit → no retrigger until it falls and rises again.
- Full FIFO with simultaneous read: FIFO holds 4 entries, ev_ready=1 on the STORE cycle → no overflow, occupancy stays 4.
- Reset mid-conversion: reset_n=0 during WAIT_DONE → next cycle sample=1, csa_reset=1, FIFO empty, busy=0; no event emitted.

Source files
------------

// File: rtl/channel_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// channel_ctrl_pkg : state encoding, event layout and sizing helpers
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package channel_ctrl_pkg;

  localparam logic [2:0] ST_READY     = 3'd0;
  localparam logic [2:0] ST_HOLD      = 3'd1;
  localparam logic [2:0] ST_CONVERT   = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_STORE     = 3'd4;
  localparam logic [2:0] ST_RESET     = 3'd5;

  localparam int DEF_ADCBITS = 10;
  localparam int DEF_TS_BITS = 24;

  typedef struct packed {
    logic                   timeout_flag;
    logic [DEF_TS_BITS-1:0] ts;
    logic [DEF_ADCBITS-1:0] adc;
  } event_t;

  function automatic int ev_width(input int adc_bits, input int ts_bits);
    return ts_bits + adc_bits + 1;
  endfunction

  localparam int EV_WIDTH = ev_width(DEF_ADCBITS, DEF_TS_BITS);

  // One shared counter serves HOLD, WAIT_DONE and RESET, so size it for the longest.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/event_fifo.sv
// ----------------------------------------------------------------------------
// event_fifo : first-word fall-through FIFO, power-of-2 depth
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module event_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;
  logic             rd_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A read in the same cycle frees the slot the write needs.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/channel_ctrl.sv
// ----------------------------------------------------------------------------
// channel_ctrl : hit -> hold -> ADC convert -> store -> CSA reset sequencer
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module channel_ctrl
  import channel_ctrl_pkg::*;
#(
  parameter int ADCBITS        = 10,
  parameter int TS_BITS        = 24,
  parameter int HOLD_CYCLES    = 2,
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     hit,
  input  logic                     done,
  input  logic [ADCBITS-1:0]       dout,
  input  logic [TS_BITS-1:0]       timestamp,
  output logic                     sample,
  output logic                     strobe,
  output logic                     csa_reset,
  output logic                     ev_valid,
  output logic [TS_BITS+ADCBITS:0] ev_data,
  input  logic                     ev_ready,
  output logic                     overflow,
  output logic                     busy
);

  localparam int EVW = ev_width(ADCBITS, TS_BITS);
  localparam int CW  = cnt_width(HOLD_CYCLES, RESET_CYCLES, TIMEOUT_CYCLES);

  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] RESET_LAST   = CW'(RESET_CYCLES - 1);

  logic               hit_meta;
  logic               hit_s;
  logic               hit_s_q;
  logic               done_meta;
  logic               done_s;
  logic               por;
  logic [2:0]         state;
  logic [CW-1:0]      cnt;
  logic [TS_BITS-1:0] ts_lat;
  logic [ADCBITS-1:0] adc_lat;
  logic               to_flag;
  logic               hit_rise;
  logic               store;
  logic               ev_rd;
  logic               fifo_full;
  logic               fifo_empty;

  assign hit_rise = hit_s && !hit_s_q;
  assign store    = (state == ST_STORE);
  assign ev_rd    = ev_valid && ev_ready;

  assign sample    = !((state == ST_CONVERT) || (state == ST_WAIT_DONE) || (state == ST_STORE));
  assign strobe    = (state == ST_CONVERT);
  // por keeps the CSA in reset while reset_n is low and for the cycle it is released.
  assign csa_reset = por || (state == ST_RESET);
  assign busy      = (state != ST_READY);
  assign ev_valid  = !fifo_empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit_meta  <= 1'b0;
      hit_s     <= 1'b0;
      hit_s_q   <= 1'b0;
      done_meta <= 1'b0;
      done_s    <= 1'b0;
      por       <= 1'b1;
      state     <= ST_READY;
      cnt       <= '0;
      ts_lat    <= '0;
      adc_lat   <= '0;
      to_flag   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      hit_meta  <= hit;
      hit_s     <= hit_meta;
      hit_s_q   <= hit_s;
      done_meta <= done;
      done_s    <= done_meta;
      por       <= 1'b0;
      case (state)
        ST_READY: begin
          if (hit_rise && enable) begin
            ts_lat  <= timestamp;
            adc_lat <= '0;
            to_flag <= 1'b0;
            cnt     <= '0;
            state   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            state <= ST_CONVERT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_CONVERT: begin
          cnt   <= '0;
          state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (done_s) begin
            adc_lat <= dout;
            state   <= ST_STORE;
          end else if (cnt == TIMEOUT_LAST) begin
            adc_lat <= '0;
            to_flag <= 1'b1;
            state   <= ST_STORE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STORE: begin
          if (fifo_full && !ev_rd) overflow <= 1'b1;
          cnt   <= '0;
          state <= ST_RESET;
        end
        ST_RESET: begin
          if (cnt == RESET_LAST) begin
            cnt   <= '0;
            state <= ST_READY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_READY;
      endcase
    end
  end

  event_fifo #(
    .WIDTH (EVW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (store),
    .wr_data ({to_flag, ts_lat, adc_lat}),
    .full    (fifo_full),
    .rd_en   (ev_rd),
    .rd_data (ev_data),
    .empty   (fifo_empty)
  );

endmodule

`default_nettype wire
